pm_stream_mux: RTL and testbench
================================

// Module: pm_stream_mux
// PURPOSE
//  Parametrised N-channel, W-bit streaming multiplexer with a registered output.
//  Successor to the combinational N:1 bit mux: per-channel valid/ready handshake,
//  selectable fixed-select or round-robin mode, out-of-range select detection.
//  Sits between N producer streams and one consumer. Sustains one beat per cycle.
// PARAMETERS
//  N   4  number of input channels (>=1)
//  W   8  data width per channel
//  SW  (localparam) select width = (N>1) ? $clog2(N) : 1
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_data    in   N*W  channel k occupies bits [k*W +: W]
//  in_valid   in   N    channel k has a beat
//  in_ready   out  N    channel k beat accepted this cycle (combinational)
//  mode       in   1    0 = FIXED (use sel), 1 = ROUND_ROBIN
//  sel        in   SW   channel index in FIXED mode; ignored in ROUND_ROBIN
//  out_data   out  W    registered data
//  out_ch     out  SW   index of channel that supplied out_data
//  out_valid  out  1    out_data valid
//  out_ready  in   1    consumer accepts out_data
//  sel_err    out  1    registered: FIXED mode with sel >= N in previous cycle
// BEHAVIOUR
//  - One clock, synchronous active-high reset. On rst: out_valid=0, out_data=0,
//    out_ch=0, sel_err=0, rr pointer=0. rst overrides all other inputs that cycle;
//    a held beat is discarded.
//  - load = ~out_valid | out_ready (output register free or draining this cycle).
//  - grant (one-hot, N bits), combinational:
//    FIXED: grant[sel]=in_valid[sel] if sel<N; else grant=0 (no channel served).
//    RR: first k with in_valid[k], scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
//  - in_ready[k] = grant[k] & load. Transfer on channel k when in_valid[k]&in_ready[k].
//  - Transfer: next cycle out_data=in_data[k], out_ch=k, out_valid=1. Latency 1 cycle.
//  - No transfer & out_ready & out_valid: out_valid->0; out_data/out_ch hold.
//  - out_valid & ~out_ready: out_data/out_ch/out_valid hold; in_ready all 0.
//  - Simultaneous drain and refill allowed: back-to-back beats, no bubble.
//  - RR pointer: after a transfer from k, ptr = (k==N-1) ? 0 : k+1. Pointer is
//    unchanged in FIXED mode and on cycles with no transfer.
//  - sel_err <= (mode==FIXED) & (sel >= N), every cycle, independent of valids.
//    Can only assert when N is not a power of two.
//  - Mode/sel changes take effect on the same-cycle grant; a held beat is never
//    altered or dropped by a mode or sel change.
//  - N==1: always grants channel 0; out_ch=0; sel_err stays 0.
//  - No data is ever duplicated or lost: exactly one out beat per accepted in beat.
// STRUCTURE
//  - Package pm_pkg: typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} pm_mode_e;
//    function pm_sel_w(n) returning select width (min 1).
//  - Sub-module pm_rr_arbiter #(N): inputs req[N], ptr[SW]; output one-hot
//    grant[N], index gnt_idx[SW], any. Implemented as double-width masked priority.
//  - Top: mode/select mux on grant, output register, pointer register, sel_err flop.
// TESTING
//  1 Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0,
//    out_data=0, sel_err=0, in_ready=0 during reset; ptr=0 after.
//  2 FIXED, N=4, W=8, sel=2, in_data ch2=8'hA5, all valid, out_ready=1 ->
//    in_ready=4'b0100; next cycle out_data=A5, out_ch=2; one beat per cycle.
//  3 RR, N=4, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence
//    0,1,2,3,0,1,2,3; with only ch1,ch3 valid -> 1,3,1,3.
//  4 Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data
//    stable, in_ready=0; on release, next beat appears the following cycle, none lost.
//  5 N=3, FIXED, sel=2'd3 with in_valid=3'b111 -> in_ready=0, sel_err=1 next
//    cycle, no output beat; switch sel=0 -> sel_err clears next cycle, ch0 served.
//  6 Mode switch RR->FIXED mid-stream with beat held (out_ready=0) -> held beat
//    delivered unchanged; subsequent beats come only from sel; rst mid-stream
//    drops held beat and restarts RR at ch0.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared types and helpers for the pm_stream_mux streaming multiplexer.
package pm_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} pm_mode_e;

  // Select width never collapses to zero, so a single channel still gets a 1-bit index.
  function automatic int pm_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping past N-1.
module pm_rr_arbiter
  import pm_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = pm_sel_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [SW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [2*N-1:0] reqDbl;
  logic [2*N-1:0] maskDbl;
  logic [2*N-1:0] masked;
  logic           found;

  // Doubling the request vector lets one low-to-high scan starting at ptr cover the wrap.
  always_comb begin
    reqDbl  = {req_i, req_i};
    maskDbl = '0;
    for (int j = 0; j < 2 * N; j++) begin
      maskDbl[j] = (j >= int'(ptr_i));
    end
    masked = reqDbl & maskDbl;
  end

  always_comb begin
    grant_o   = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (masked[j] && !found) begin
        found          = 1'b1;
        grant_o[j % N] = 1'b1;
        gnt_idx_o      = SW'(j % N);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/pm_stream_mux.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage.
module pm_stream_mux
  import pm_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = pm_sel_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N*W-1:0] in_data_i,
  input  logic [N-1:0]  in_valid_i,
  output logic [N-1:0]  in_ready_o,
  input  logic          mode_i,
  input  logic [SW-1:0] sel_i,
  output logic [W-1:0]  out_data_o,
  output logic [SW-1:0] out_ch_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          sel_err_o
);

  logic [N-1:0]  rrGrant, grant;
  logic [SW-1:0] rrIdx, grantIdx, selIdx;
  logic          rrAny, anyGrant, selOk, load, xfer;

  logic          outValid_q, outValid_d;
  logic [W-1:0]  outData_q, outData_d;
  logic [SW-1:0] outCh_q, outCh_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          selErr_q, selErr_d;

  pm_rr_arbiter #(.N(N)) uArb (
    .req_i     (in_valid_i),
    .ptr_i     (ptr_q),
    .grant_o   (rrGrant),
    .gnt_idx_o (rrIdx),
    .any_o     (rrAny)
  );

  // A single channel ignores sel entirely and is always in range.
  assign selIdx = (N == 1) ? '0 : sel_i;
  assign selOk  = (N == 1) || (int'(sel_i) < N);

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    if (mode_i == MODE_RR) begin
      grant    = rrGrant;
      grantIdx = rrIdx;
      anyGrant = rrAny;
    end else if (selOk) begin
      grant[selIdx] = in_valid_i[selIdx];
      grantIdx      = selIdx;
      anyGrant      = in_valid_i[selIdx];
    end
  end

  assign load       = ~outValid_q | out_ready_i;
  assign in_ready_o = grant & {N{load & ~rst_i}};
  assign xfer       = anyGrant & load & ~rst_i;

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      outValid_d = 1'b1;
      outData_d  = in_data_i[int'(grantIdx) * W +: W];
      outCh_d    = grantIdx;
      if (mode_i == MODE_RR) begin
        ptr_d = (int'(grantIdx) == N - 1) ? '0 : grantIdx + SW'(1);
      end
    end else if (out_ready_i) begin
      outValid_d = 1'b0;
    end
    selErr_d = (N > 1) && (mode_i == MODE_FIXED) && !selOk;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
      ptr_q      <= '0;
      selErr_q   <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      ptr_q      <= ptr_d;
      selErr_q   <= selErr_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;
  assign out_ch_o    = outCh_q;
  assign sel_err_o   = selErr_q;

endmodule

// File: tb/tb_pm_stream_mux.sv
// Bench for pm_stream_mux: an N=4 and an N=3 instance checked every cycle against
// a channel-scanning reference model, plus directed scenario checks.
module tb_pm_stream_mux;
  import pm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, mode4, outValid4, outReady4, selErr4;
  logic [31:0] inData4;
  logic [3:0]  inValid4, inReady4;
  logic [1:0]  sel4, outCh4;
  logic [7:0]  outData4;

  logic        rst3, mode3, outValid3, outReady3, selErr3;
  logic [23:0] inData3;
  logic [2:0]  inValid3, inReady3;
  logic [1:0]  sel3, outCh3;
  logic [7:0]  outData3;

  int vectors = 0;
  int miscompares = 0;

  logic       mValid [2] = '{1'b0, 1'b0};
  logic [7:0] mData  [2] = '{8'h00, 8'h00};
  int         mCh    [2] = '{0, 0};
  int         mPtr   [2] = '{0, 0};
  logic       mErr   [2] = '{1'b0, 1'b0};

  pm_stream_mux #(.N(4), .W(8)) dut4 (
    .clk_i(clk), .rst_i(rst4), .in_data_i(inData4), .in_valid_i(inValid4),
    .in_ready_o(inReady4), .mode_i(mode4), .sel_i(sel4), .out_data_o(outData4),
    .out_ch_o(outCh4), .out_valid_o(outValid4), .out_ready_i(outReady4),
    .sel_err_o(selErr4)
  );

  pm_stream_mux #(.N(3), .W(8)) dut3 (
    .clk_i(clk), .rst_i(rst3), .in_data_i(inData3), .in_valid_i(inValid3),
    .in_ready_o(inReady3), .mode_i(mode3), .sel_i(sel3), .out_data_o(outData3),
    .out_ch_o(outCh3), .out_valid_o(outValid3), .out_ready_i(outReady3),
    .sel_err_o(selErr3)
  );

  // Which channel the rules say gets served this cycle, or -1 for none.
  function automatic int refPick(int n, logic m, int sel, logic [3:0] v, int ptr);
    int s;
    if (m == MODE_FIXED) begin
      s = (n == 1) ? 0 : sel;
      if (s < n && v[s]) return s;
      return -1;
    end
    for (int o = 0; o < n; o++) begin
      if (v[(ptr + o) % n]) return (ptr + o) % n;
    end
    return -1;
  endfunction

  // Check in_ready now, advance both models one clock, then check the registered outputs.
  task automatic step();
    logic       r, m, ord, gv, ge;
    logic [3:0] v, gotReady, expReady;
    logic [7:0] dat [4];
    logic [7:0] gd;
    int         n, s, pick, gc;
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      if (inst == 0) begin
        n = 4; r = rst4; m = mode4; s = int'(sel4); v = inValid4; ord = outReady4;
        gotReady = inReady4;
        for (int k = 0; k < 4; k++) dat[k] = inData4[k*8 +: 8];
      end else begin
        n = 3; r = rst3; m = mode3; s = int'(sel3); v = {1'b0, inValid3}; ord = outReady3;
        gotReady = {1'b0, inReady3};
        for (int k = 0; k < 3; k++) dat[k] = inData3[k*8 +: 8];
        dat[3] = 8'h00;
      end
      pick = refPick(n, m, s, v, mPtr[inst]);
      expReady = (!r && (!mValid[inst] || ord) && pick >= 0) ? (4'b0001 << pick) : 4'b0000;
      vectors++;
      if (gotReady !== expReady) begin
        miscompares++;
        $display("[TB] FAIL in_ready inst%0d: got %b expected %b", inst, gotReady, expReady);
      end
      if (r) begin
        mValid[inst] = 1'b0; mData[inst] = 8'h00; mCh[inst] = 0; mPtr[inst] = 0; mErr[inst] = 1'b0;
      end else begin
        if (expReady != 4'b0000) begin
          mValid[inst] = 1'b1;
          mData[inst]  = dat[pick];
          mCh[inst]    = pick;
          if (m == MODE_RR) mPtr[inst] = (pick + 1) % n;
        end else if (ord) begin
          mValid[inst] = 1'b0;
        end
        mErr[inst] = (m == MODE_FIXED) && (s >= n);
      end
    end
    @(posedge clk);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      if (inst == 0) begin
        gv = outValid4; gd = outData4; gc = int'(outCh4); ge = selErr4;
      end else begin
        gv = outValid3; gd = outData3; gc = int'(outCh3); ge = selErr3;
      end
      vectors += 4;
      if (gv !== mValid[inst]) begin
        miscompares++;
        $display("[TB] FAIL out_valid inst%0d: got %b expected %b", inst, gv, mValid[inst]);
      end
      if (gd !== mData[inst]) begin
        miscompares++;
        $display("[TB] FAIL out_data inst%0d: got %h expected %h", inst, gd, mData[inst]);
      end
      if (gc != mCh[inst]) begin
        miscompares++;
        $display("[TB] FAIL out_ch inst%0d: got %0d expected %0d", inst, gc, mCh[inst]);
      end
      if (ge !== mErr[inst]) begin
        miscompares++;
        $display("[TB] FAIL sel_err inst%0d: got %b expected %b", inst, ge, mErr[inst]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst3 = 1'b1;
    inValid4 = 4'hF; inValid3 = 3'h7; outReady4 = 1'b0; outReady3 = 1'b0;
    mode4 = MODE_RR; mode3 = MODE_RR; sel4 = 2'd0; sel3 = 2'd0;
    inData4 = $urandom; inData3 = 24'($urandom);
    step();
    step();
    vectors++;
    if (outValid4 !== 1'b0 || outData4 !== 8'h00 || selErr4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%b d=%h e=%b expected v=0 d=00 e=0",
               outValid4, outData4, selErr4);
    end
    rst4 = 1'b0; rst3 = 1'b0;
    inValid4 = 4'h0; inValid3 = 3'h0; outReady4 = 1'b1; outReady3 = 1'b1;
    mode4 = MODE_FIXED; mode3 = MODE_FIXED;
    step();
  endtask

  task automatic test_fixed();
    mode4 = MODE_FIXED; sel4 = 2'd2; inValid4 = 4'hF; outReady4 = 1'b1;
    inData4 = $urandom;
    inData4[23:16] = 8'hA5;
    #1;
    vectors++;
    if (inReady4 !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL fixed_ready: got %b expected 0100", inReady4);
    end
    step();
    vectors++;
    if (outData4 !== 8'hA5 || outCh4 !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL fixed_beat: got %h/ch%0d expected a5/ch2", outData4, outCh4);
    end
    for (int i = 0; i < 4; i++) begin
      inData4 = $urandom;
      step();
    end
  endtask

  task automatic test_round_robin();
    int seqB [4] = '{1, 3, 1, 3};
    mode4 = MODE_RR; inValid4 = 4'hF; outReady4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inData4 = $urandom;
      step();
      vectors++;
      if (int'(outCh4) != i % 4) begin
        miscompares++;
        $display("[TB] FAIL rr_all beat%0d: got ch%0d expected ch%0d", i, outCh4, i % 4);
      end
    end
    inValid4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      inData4 = $urandom;
      step();
      vectors++;
      if (int'(outCh4) != seqB[i]) begin
        miscompares++;
        $display("[TB] FAIL rr_sparse beat%0d: got ch%0d expected ch%0d", i, outCh4, seqB[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    mode4 = MODE_RR; inValid4 = 4'hF; outReady4 = 1'b1; inData4 = $urandom;
    step();
    held = outData4;
    outReady4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inData4 = $urandom;
      step();
      vectors++;
      if (outData4 !== held || inReady4 !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold: got d=%h rdy=%b expected d=%h rdy=0000",
                 outData4, inReady4, held);
      end
    end
    outReady4 = 1'b1;
    step();
    step();
  endtask

  task automatic test_sel_err();
    mode3 = MODE_FIXED; sel3 = 2'd3; inValid3 = 3'b111; outReady3 = 1'b1;
    inData3 = 24'($urandom);
    #1;
    vectors++;
    if (inReady3 !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL selerr_ready: got %b expected 000", inReady3);
    end
    step();
    vectors++;
    if (selErr3 !== 1'b1 || outValid3 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL selerr_set: got e=%b v=%b expected e=1 v=0", selErr3, outValid3);
    end
    sel3 = 2'd0;
    step();
    vectors++;
    if (selErr3 !== 1'b0 || outValid3 !== 1'b1 || outCh3 !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL selerr_clear: got e=%b v=%b ch%0d expected e=0 v=1 ch0",
               selErr3, outValid3, outCh3);
    end
    inValid3 = 3'b000;
    step();
  endtask

  task automatic test_mode_switch();
    logic [7:0] held;
    mode4 = MODE_RR; inValid4 = 4'hF; outReady4 = 1'b1; inData4 = $urandom;
    step();
    held = outData4;
    outReady4 = 1'b0; mode4 = MODE_FIXED; sel4 = 2'd1;
    for (int i = 0; i < 2; i++) begin
      inData4 = $urandom;
      step();
      vectors++;
      if (outData4 !== held) begin
        miscompares++;
        $display("[TB] FAIL switch_hold: got %h expected %h", outData4, held);
      end
    end
    outReady4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inData4 = $urandom;
      held = inData4[15:8];
      step();
      vectors++;
      if (outCh4 !== 2'd1 || outData4 !== held) begin
        miscompares++;
        $display("[TB] FAIL switch_fixed: got %h/ch%0d expected %h/ch1", outData4, outCh4, held);
      end
    end
    mode4 = MODE_RR; outReady4 = 1'b0;
    step();
    rst4 = 1'b1;
    step();
    vectors++;
    if (outValid4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_drop: got %b expected 0", outValid4);
    end
    rst4 = 1'b0; outReady4 = 1'b1; inData4 = $urandom;
    step();
    vectors++;
    if (outValid4 !== 1'b1 || outCh4 !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_restart: got v=%b ch%0d expected v=1 ch0", outValid4, outCh4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst4 = ($urandom_range(0, 40) == 0);
      rst3 = ($urandom_range(0, 40) == 0);
      mode4 = 1'($urandom_range(0, 1));
      mode3 = 1'($urandom_range(0, 1));
      sel4 = 2'($urandom);
      sel3 = 2'($urandom);
      inValid4 = 4'($urandom);
      inValid3 = 3'($urandom);
      outReady4 = ($urandom_range(0, 3) != 0);
      outReady3 = ($urandom_range(0, 3) != 0);
      inData4 = $urandom;
      inData3 = 24'($urandom);
      step();
    end
    rst4 = 1'b0; rst3 = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1; mode4 = MODE_FIXED; mode3 = MODE_FIXED;
    sel4 = 2'd0; sel3 = 2'd0; inValid4 = 4'h0; inValid3 = 3'h0;
    outReady4 = 1'b0; outReady3 = 1'b0; inData4 = '0; inData3 = '0;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_sel_err();
    test_mode_switch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
